// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the switch debounce slice.
package sw_debounce_pkg;

  // Per-bit debouncer state: STABLE when the synchronized level matches the
  // committed output, PENDING while a different level is being timed.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_t;

  // 1 ms of agreement at 50 MHz before a switch edit is accepted.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int CLK_HZ                  = 50_000_000;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchronizer chain, disagreement counter and commit FSM.
// 'commit' is the combinational "this edge will commit" flag; the parent
// registers it so the strobe lines up with the d_out update.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic d_in,
  output logic d_out,
  output logic commit,
  output logic pending
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_next_s;
  logic                   out_r;
  logic                   out_next_s;
  logic                   commit_s;
  db_state_t              state_s;

  // Shift the raw asynchronous level through the synchronizer chain.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d_in};
    end
  end

  assign sync_s  = sync_r[SYNC_STAGES-1];
  assign state_s = (sync_s == out_r) ? ST_STABLE : ST_PENDING;

  // Next counter/output: a bounce back to the committed level cancels the
  // pending change; the last counted cycle of disagreement commits it.
  always_comb begin
    cnt_next_s = cnt_r;
    out_next_s = out_r;
    commit_s   = 1'b0;
    case (state_s)
      ST_STABLE: begin
        cnt_next_s = '0;
      end
      ST_PENDING: begin
        if (cnt_r == CNT_LAST) begin
          out_next_s = sync_s;
          cnt_next_s = '0;
          commit_s   = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_next_s = '0;
      end
    endcase
  end

  // Register the counter and the committed output level.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r <= '0;
      out_r <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      out_r <= out_next_s;
    end
  end

  assign d_out   = out_r;
  assign commit  = commit_s;
  assign pending = (state_s == ST_PENDING);

endmodule

// File: rtl/sw_debounce.sv
// Debounces the board slide switches before they reach the hex decoders and
// publishes a one-cycle change strobe with a per-bit mask of committed bits.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             sw_changed,
  output logic [WIDTH-1:0] changed_mask,
  output logic             busy
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sw_debounce: SYNC_STAGES must be 2 or more");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("sw_debounce: DEBOUNCE_CYCLES must be 1 or more");
  end

  logic [WIDTH-1:0] commit_s;
  logic [WIDTH-1:0] pending_s;
  logic [WIDTH-1:0] changed_mask_r;
  logic             sw_changed_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .CLOCK_50(CLOCK_50),
      .RESET_N (RESET_N),
      .d_in    (sw_in[i]),
      .d_out   (sw_out[i]),
      .commit  (commit_s[i]),
      .pending (pending_s[i])
    );
  end

  // Register the commit flags so strobe and mask coincide with sw_out.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      changed_mask_r <= '0;
      sw_changed_r   <= 1'b0;
    end else begin
      changed_mask_r <= commit_s;
      sw_changed_r   <= |commit_s;
    end
  end

  assign changed_mask = changed_mask_r;
  assign sw_changed   = sw_changed_r;
  assign busy         = |pending_s;

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

  localparam int W   = 18;
  localparam int LAT = 5;   // commit edge = first sampling edge + LAT

  typedef struct {
    int unsigned    edge_no;
    logic [W-1:0]   out;
    logic [W-1:0]   mask;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_in;
  logic [W-1:0] sw_out;
  logic         sw_changed;
  logic [W-1:0] changed_mask;
  logic         busy;

  int unsigned total;
  int unsigned bad;
  int unsigned cyc;
  int unsigned k;
  exp_t        sb[$];

  sw_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50    (clk),
    .RESET_N     (rst_n),
    .sw_in       (sw_in),
    .sw_out      (sw_out),
    .sw_changed  (sw_changed),
    .changed_mask(changed_mask),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Scoreboard consumer: every strobe must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sw_changed) begin
        if (sb.size() == 0) begin
          chk("strobe_expected", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_edge", cyc, e.edge_no);
          chk("commit_sw_out", 32'(sw_out), 32'(e.out));
          chk("commit_mask", 32'(changed_mask), 32'(e.mask));
        end
      end else begin
        chk("idle_mask", 32'(changed_mask), 32'd0);
      end
    end
  end

  // Drive a new switch level away from the clock edge; k = first sampling edge.
  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    sw_in = v;
    k = cyc + 1;
  endtask

  task automatic expect_commit(input int unsigned e_no, input logic [W-1:0] o, input logic [W-1:0] m);
    exp_t e;
    e.edge_no = e_no;
    e.out = o;
    e.mask = m;
    sb.push_back(e);
  endtask

  // Wait (bounded) until every expected commit has been seen.
  task automatic drain(input string tag);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] wide;
    total = 0;
    bad = 0;
    cyc = 0;
    rst_n = 1'b0;
    sw_in = 18'h3FFFF;

    // Reset held with all switches high.
    repeat (3) @(negedge clk);
    chk("rst_sw_out", 32'(sw_out), 32'd0);
    chk("rst_sw_changed", 32'(sw_changed), 32'd0);
    chk("rst_mask", 32'(changed_mask), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = cyc + 1;
    expect_commit(k + LAT, 18'h3FFFF, 18'h3FFFF);
    drain("drain_release");

    // Back to all zero, then a clean single-bit edge with busy tracking.
    drive(18'h00000);
    expect_commit(k + LAT, 18'h00000, 18'h3FFFF);
    drain("drain_zero");
    drive(18'h00001);
    expect_commit(k + LAT, 18'h00001, 18'h00001);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk($sformatf("busy_k%0d", j), 32'(busy), ((j >= 1) && (j <= 4)) ? 32'd1 : 32'd0);
    end
    drain("drain_clean");

    // Glitch on bit 4 for 3 cycles: never committed.
    drive(18'h00011);
    repeat (2) @(negedge clk);
    drive(18'h00001);
    repeat (10) @(negedge clk);
    chk("glitch_sw_out", 32'(sw_out), 32'h1);
    chk("glitch_busy", 32'(busy), 32'd0);

    // Bounce 1,0,1 on bit 5: commit timed from the last transition.
    drive(18'h00021);
    drive(18'h00001);
    drive(18'h00021);
    expect_commit(k + LAT, 18'h00021, 18'h00020);
    drain("drain_bounce");

    // Simultaneous commits, then a nibble edit.
    drive(18'h00F21);
    expect_commit(k + LAT, 18'h00F21, 18'h00F00);
    drain("drain_simul");
    drive(18'h0AF21);
    expect_commit(k + LAT, 18'h0AF21, 18'h0A000);
    drain("drain_nibble");

    // Back-to-back commits on consecutive edges stay separate.
    drive(18'h1AF21);
    expect_commit(k + LAT, 18'h1AF21, 18'h10000);
    drive(18'h3AF21);
    expect_commit(k + LAT, 18'h3AF21, 18'h20000);
    drain("drain_b2b");

    // Asynchronous reset while bit 2 is pending with cnt=2.
    drive(18'h3AF25);
    repeat (4) @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sw_out", 32'(sw_out), 32'd0);
    chk("mid_rst_changed", 32'(sw_changed), 32'd0);
    chk("mid_rst_mask", 32'(changed_mask), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = cyc + 1;
    expect_commit(k + LAT, 18'h3AF25, 18'h3AF25);
    drain("drain_mid_rst");

    // End-to-end nibble decode of the debounced value.
    drive(18'h0000F);
    expect_commit(k + LAT, 18'h0000F, 18'h3AF2A);
    drain("drain_hex");
    wide = {14'd0, sw_out};
    chk("hex0", 32'(hex7(wide[3:0])), 32'(7'b0001110));
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("hex%0d", i), 32'(hex7(wide[4*i +: 4])), 32'(7'b1000000));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
